instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the decoder's control interface.
- Owns the PC, fetches 16-bit Thumb-style instructions from instruction memory and presents PC/instr to the control decoder one at a time.
- Consumes the decoder's Branch, brSel and brEx outputs to select the next PC.
- Provides the link address for BL write-back.

Parameters:
PC_W, 16, PC and instruction-memory address width (bits)
RESET_PC, 16'h0000, PC value loaded on reset (bit 0 forced to 0)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  one-cycle fetch request strobe
imem_addr  output  PC_W  fetch address (= PC)
imem_valid  input  1  response valid; may arrive in the request cycle or any later cycle
imem_rdata  input  16  instruction word, sampled when imem_valid=1 and accepted
stall  input  1  decoder/datapath not ready; hold current instruction
Branch  input  1  decoder: current instruction is a branch class
brSel  input  2  decoder next-PC select: 00 BL, 01 Bcond-taken, 10 B, 11 sequential
brEx  input  1  decoder: BX, target from register
bxTarget  input  PC_W  register value for BX
PC  output  PC_W  address of presented instruction
instr  output  16  presented instruction
instrValid  output  1  PC/instr valid for decode
linkAddr  output  PC_W  PC+2, write data for BL

Behaviour:
- Reset values: PC=RESET_PC; instr=16'hBF00 (NOOP); instrValid=0; imem_req=0; imem_addr=RESET_PC; state=FETCH. Reset wins over every other event in the same cycle and abandons any outstanding request.
- FSM:
  - FETCH: imem_req=1 for exactly one cycle, imem_addr=PC. If imem_valid=1 in this same cycle, capture the word and go to ISSUE. Otherwise go to WAIT.
  - WAIT: imem_req=0. Stay until imem_valid=1, then capture the word into instr and go to ISSUE.
  - ISSUE: instrValid=1.
    - stall=1: PC and instr hold unchanged, no request issued.
    - stall=0: load PC=nextPC and go to FETCH.
- imem_valid outside FETCH/WAIT is ignored.
- Minimum issue latency: 1 cycle from FETCH to instrValid, with a zero-wait memory. Minimum throughput: one instruction per 2 cycles.
- nextPC (all arithmetic mod 2^PC_W; sext = sign-extend):
  - brEx=1 (priority over brSel): bxTarget with bit 0 cleared.
  - Branch=0 or brSel=11: PC+2.
  - brSel=01: PC+4+(sext(instr[7:0])<<1).
  - brSel=10: PC+4+(sext(instr[10:0])<<1).
  - brSel=00: PC+4+(sext(instr[5:0])<<1).
- PC[0] is always 0. Wrap-around is silent: 16'hFFFE+2 → 16'h0000.
- linkAddr=PC+2, combinational, valid whenever instrValid=1.
- stall=1 together with a taken branch: the redirect is deferred until the first cycle with stall=0. No PC change occurs while stalled.

Optional Feature:
BRANCH_BUBBLE_EN
- Defined: when leaving ISSUE with a redirect (brEx=1, or Branch=1 with brSel≠11), the unit passes through an extra BUBBLE state for one cycle before FETCH. In BUBBLE:
  - instrValid=1, instr=16'hBF00 (NOOP), PC=target, imem_req=0.
  - stall in BUBBLE holds the state.
- Undefined: no BUBBLE state; redirect goes directly to FETCH.

Test Plan:
1. Reset with RESET_PC=16'h0000, then zero-wait memory returning 16'h2005: first imem_req with addr 16'h0000 one cycle after reset releases; next cycle instrValid=1, instr=16'h2005, PC=16'h0000, linkAddr=16'h0002. Next fetch is at 16'h0002.
2. Memory delays imem_valid by 3 cycles: imem_req pulses once, instrValid stays 0 for 3 cycles, then instr is presented; no duplicate request.
3. PC=16'h0010, instr=16'hD0FE (BEQ), Branch=1, brSel=01: next fetch addr = 16'h0010 (0x10+4-4). With brSel=11 it is 16'h0012.
4. brEx=1, bxTarget=16'h0125: next PC = 16'h0124. stall=1 for 4 cycles first: PC/instr hold for all 4 cycles and no imem_req is issued.
5. PC=16'hFFFE, sequential: next imem_addr=16'h0000. Reset asserted while in WAIT, then a late imem_valid: PC returns to RESET_PC and the stale word is ignored.
6. With BRANCH_BUBBLE_EN, B taken (instr=16'hE002 at PC=16'h0020): one cycle with instrValid=1, instr=16'hBF00, PC=16'h0028, then fetch at 16'h0028.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and fetches 16-bit instructions from instruction memory.
// It presents each instruction to the control decoder and selects the next PC from the
// decoder's branch controls.
// Optional macro BRANCH_BUBBLE_EN: after every redirect, present one NOOP bubble at the target.
module instr_fetch_unit #(
   parameter int unsigned     PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [15:0]     imem_rdata,
   input  logic            stall,
   input  logic            Branch,
   input  logic [1:0]      brSel,
   input  logic            brEx,
   input  logic [PC_W-1:0] bxTarget,
   output logic [PC_W-1:0] PC,
   output logic [15:0]     instr,
   output logic            instrValid,
   output logic [PC_W-1:0] linkAddr
);

   localparam int unsigned     INSTR_W   = 16;
   localparam logic [INSTR_W-1:0] NOOP   = 16'hBF00;
   localparam logic [PC_W-1:0] PC_ALIGN  = ~PC_W'(1);
   localparam logic [PC_W-1:0] RESET_VAL = RESET_PC & PC_ALIGN;

   // S_BUBBLE is reachable only when BRANCH_BUBBLE_EN is defined
   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_WAIT   = 2'd1,
      S_ISSUE  = 2'd2,
      S_BUBBLE = 2'd3
   } state_t;

   state_t             r_state;
   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_req;
   logic               r_valid;

   state_t             w_state_nxt;
   logic [PC_W-1:0]    w_pc_nxt;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic               w_req_nxt;
   logic               w_valid_nxt;

   logic [PC_W-1:0]    w_seq;
   logic [PC_W-1:0]    w_rel_base;
   logic [PC_W-1:0]    w_off_bl;
   logic [PC_W-1:0]    w_off_bcond;
   logic [PC_W-1:0]    w_off_b;
   logic [PC_W-1:0]    w_target;
`ifdef BRANCH_BUBBLE_EN
   logic               w_redirect;
`endif

   // Halfword-scaled, sign-extended branch offsets taken from the presented instruction
   assign w_seq       = r_pc + PC_W'(2);
   assign w_rel_base  = r_pc + PC_W'(4);
   assign w_off_bl    = {{(PC_W-7){r_instr[5]}},   r_instr[5:0],  1'b0};
   assign w_off_bcond = {{(PC_W-9){r_instr[7]}},   r_instr[7:0],  1'b0};
   assign w_off_b     = {{(PC_W-12){r_instr[10]}}, r_instr[10:0], 1'b0};

`ifdef BRANCH_BUBBLE_EN
   assign w_redirect = brEx | (Branch & (brSel != 2'b11));
`endif

   // Next-PC select: BX has priority, then the decoder's brSel when a branch is flagged
   always_comb begin
      w_target = w_seq;
      if (brEx) begin
         w_target = bxTarget & PC_ALIGN;
      end else if (Branch) begin
         case (brSel)
            2'b00:   w_target = w_rel_base + w_off_bl;
            2'b01:   w_target = w_rel_base + w_off_bcond;
            2'b10:   w_target = w_rel_base + w_off_b;
            default: w_target = w_seq;
         endcase
      end
   end

   // Fetch FSM next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_req_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      case (r_state)
         S_FETCH: begin
            // r_req low only in the first cycle after reset: no request yet, responses ignored
            if (r_req) begin
               if (imem_valid) begin
                  w_instr_nxt = imem_rdata;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (imem_valid) begin
               w_instr_nxt = imem_rdata;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               w_pc_nxt    = w_target;
               w_state_nxt = S_FETCH;
`ifdef BRANCH_BUBBLE_EN
               if (w_redirect) begin
                  w_instr_nxt = NOOP;
                  w_state_nxt = S_BUBBLE;
               end
`endif
            end
         end
         S_BUBBLE: begin
`ifdef BRANCH_BUBBLE_EN
            if (!stall) begin
               w_state_nxt = S_FETCH;
            end
`else
            w_state_nxt = S_FETCH;
`endif
         end
         default: w_state_nxt = S_FETCH;
      endcase
      w_req_nxt   = (w_state_nxt == S_FETCH);
      w_valid_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_BUBBLE);
   end

   // State and registered outputs; reset abandons any outstanding request
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_VAL;
         r_instr <= NOOP;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
         r_req   <= w_req_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_pc;
   assign PC         = r_pc;
   assign instr      = r_instr;
   assign instrValid = r_valid;
   assign linkAddr   = w_seq;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized transaction-level checks of instr_fetch_unit.
// Define BRANCH_BUBBLE_EN for both files to check the bubble build.
module tb_instr_fetch_unit;

   localparam int unsigned PC_W     = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam logic [15:0] NOOP     = 16'hBF00;

   logic            clk = 1'b0;
   logic            reset;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [15:0]     imem_rdata;
   logic            stall;
   logic            Branch;
   logic [1:0]      brSel;
   logic            brEx;
   logic [PC_W-1:0] bxTarget;
   logic [PC_W-1:0] PC;
   logic [15:0]     instr;
   logic            instrValid;
   logic [PC_W-1:0] linkAddr;

   int              checks = 0;
   int              errors = 0;
   logic [15:0]     exp_pc;

   instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .stall      (stall),
      .Branch     (Branch),
      .brSel      (brSel),
      .brEx       (brEx),
      .bxTarget   (bxTarget),
      .PC         (PC),
      .instr      (instr),
      .instrValid (instrValid),
      .linkAddr   (linkAddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Next PC straight from the branch rules, using integer arithmetic
   function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] w,
                                              input logic br, input logic [1:0] sel,
                                              input logic ex, input logic [15:0] bxt);
      int off;
      int tgt;
      if (ex) return 16'((int'(bxt) / 2) * 2);
      if (!br || sel == 2'b11) return 16'(int'(pc) + 2);
      case (sel)
         2'b01:   begin off = int'(w[7:0]);  if (off >= 128)  off -= 256;  end
         2'b10:   begin off = int'(w[10:0]); if (off >= 1024) off -= 2048; end
         default: begin off = int'(w[5:0]);  if (off >= 32)   off -= 64;   end
      endcase
      tgt = int'(pc) + 4 + 2 * off;
      return 16'(tgt);
   endfunction

   // One instruction: request at exp_pc, memory answers after lat cycles, decoder stalls
   // nstall cycles with its branch decision already driven, then releases.
   // Entry/exit: just after a negedge in a cycle where a request is expected.
   task automatic run_instr(input int lat, input int nstall, input logic [15:0] word,
                            input logic br, input logic [1:0] sel, input logic ex,
                            input logic [15:0] bxt);
      logic [15:0] nxt;
      chk("fetch_req",  32'(imem_req),   1);
      chk("fetch_addr", 32'(imem_addr),  32'(exp_pc));
      chk("fetch_vld",  32'(instrValid), 0);
      for (int k = 0; k < lat; k++) begin
         imem_valid = 1'b0;
         imem_rdata = 16'($urandom);
         Branch     = 1'($urandom);
         brEx       = 1'($urandom);
         @(negedge clk);
         chk("wait_noreq", 32'(imem_req),   0);
         chk("wait_vld",   32'(instrValid), 0);
      end
      imem_valid = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      chk("issue_vld",   32'(instrValid), 1);
      chk("issue_instr", 32'(instr),      32'(word));
      chk("issue_pc",    32'(PC),         32'(exp_pc));
      chk("issue_link",  32'(linkAddr),   32'(16'(exp_pc + 16'd2)));
      chk("issue_noreq", 32'(imem_req),   0);
      Branch   = br;
      brSel    = sel;
      brEx     = ex;
      bxTarget = bxt;
      for (int s = 0; s < nstall; s++) begin
         stall      = 1'b1;
         imem_valid = 1'($urandom);
         @(negedge clk);
         chk("stall_pc",    32'(PC),         32'(exp_pc));
         chk("stall_instr", 32'(instr),      32'(word));
         chk("stall_vld",   32'(instrValid), 1);
         chk("stall_noreq", 32'(imem_req),   0);
      end
      stall      = 1'b0;
      imem_valid = 1'b0;
      nxt = model_next(exp_pc, word, br, sel, ex, bxt);
      @(negedge clk);
      Branch = 1'b0;
      brSel  = 2'b11;
      brEx   = 1'b0;
`ifdef BRANCH_BUBBLE_EN
      if (ex || (br && sel != 2'b11)) begin
         int bs;
         bs = int'($urandom_range(0, 1));
         chk("bub_vld",   32'(instrValid), 1);
         chk("bub_instr", 32'(instr),      32'(NOOP));
         chk("bub_pc",    32'(PC),         32'(nxt));
         chk("bub_noreq", 32'(imem_req),   0);
         for (int s = 0; s < bs; s++) begin
            stall = 1'b1;
            @(negedge clk);
            chk("bubst_vld",   32'(instrValid), 1);
            chk("bubst_instr", 32'(instr),      32'(NOOP));
            chk("bubst_pc",    32'(PC),         32'(nxt));
            chk("bubst_noreq", 32'(imem_req),   0);
         end
         stall = 1'b0;
         @(negedge clk);
      end
`endif
      exp_pc = nxt;
   endtask

   // Directed test steps followed by a randomized instruction stream
   initial begin
      reset      = 1'b1;
      imem_valid = 1'b0;
      imem_rdata = 16'h0000;
      stall      = 1'b0;
      Branch     = 1'b0;
      brSel      = 2'b11;
      brEx       = 1'b0;
      bxTarget   = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_pc",    32'(PC),         32'(RESET_PC));
      chk("rst_addr",  32'(imem_addr),  32'(RESET_PC));
      chk("rst_instr", 32'(instr),      32'(NOOP));
      chk("rst_vld",   32'(instrValid), 0);
      chk("rst_req",   32'(imem_req),   0);
      reset = 1'b0;
      @(negedge clk);
      exp_pc = RESET_PC;

      // zero-wait first fetch, then a 3-cycle memory
      run_instr(0, 0, 16'h2005, 1'b0, 2'b11, 1'b0, 16'h0000);
      chk("t1_next_addr", 32'(imem_addr), 32'(16'h0002));
      run_instr(3, 0, 16'h1C00, 1'b0, 2'b11, 1'b0, 16'h0000);

      // conditional branch at 0x0010, taken then sequential
      run_instr(0, 0, 16'h4700, 1'b0, 2'b11, 1'b1, 16'h0010);
      run_instr(0, 0, 16'hD0FE, 1'b1, 2'b01, 1'b0, 16'h0000);
      chk("t3_taken_addr", 32'(imem_addr), 32'(16'h0010));
      run_instr(0, 0, 16'hD0FE, 1'b1, 2'b11, 1'b0, 16'h0000);
      chk("t3_seq_addr", 32'(imem_addr), 32'(16'h0012));

      // BX stalled for 4 cycles
      run_instr(1, 4, 16'h4788, 1'b0, 2'b11, 1'b1, 16'h0125);
      chk("t4_bx_addr", 32'(imem_addr), 32'(16'h0124));

      // wrap-around from 0xFFFE
      run_instr(0, 0, 16'h4700, 1'b0, 2'b11, 1'b1, 16'hFFFF);
      run_instr(2, 1, 16'hBF00, 1'b0, 2'b11, 1'b0, 16'h0000);
      chk("t5_wrap_addr", 32'(imem_addr), 32'(16'h0000));

      // B at 0x0020 to 0x0028, then a BL with a negative offset
      run_instr(0, 0, 16'h4700, 1'b0, 2'b11, 1'b1, 16'h0020);
      run_instr(0, 0, 16'hE002, 1'b1, 2'b10, 1'b0, 16'h0000);
      chk("t6_b_addr", 32'(imem_addr), 32'(16'h0028));
      run_instr(0, 1, 16'hF03F, 1'b1, 2'b00, 1'b0, 16'h0000);
      chk("bl_neg_addr", 32'(imem_addr), 32'(16'h002A));

      // reset while waiting on memory; the late response must be dropped
      chk("rw_req", 32'(imem_req), 1);
      imem_valid = 1'b0;
      @(negedge clk);
      chk("rw_wait_noreq", 32'(imem_req), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rw_pc",    32'(PC),         32'(RESET_PC));
      chk("rw_vld",   32'(instrValid), 0);
      chk("rw_req0",  32'(imem_req),   0);
      chk("rw_instr", 32'(instr),      32'(NOOP));
      reset      = 1'b0;
      imem_valid = 1'b1;
      imem_rdata = 16'hDEAD;
      @(negedge clk);
      imem_valid = 1'b0;
      exp_pc = RESET_PC;
      run_instr(1, 0, 16'h4600, 1'b0, 2'b11, 1'b0, 16'h0000);

      // randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   16'($urandom), 1'($urandom), 2'($urandom),
                   ($urandom_range(0, 7) == 0), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
